// File: rtl/demux1_8_deser.sv
// demux1_8_deser: serial-to-parallel deserializer.
// Each accepted bit is steered by a 3-bit slot counter through a 1:8 decode
// into an assembly register. A finished byte moves into a one-entry output
// buffer that the consumer drains with a valid/ready handshake.
module demux1_8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  input  logic       flush,
  output logic [7:0] out_word,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] slot_onehot,
  output logic [2:0] bit_count
);

  logic [2:0] count_reg;
  logic [7:0] asm_reg;
  logic [7:0] asm_next;
  logic [7:0] word_reg;
  logic       valid_reg;
  logic [2:0] slot_idx;
  logic       accept;
  logic       take;
  logic       complete;

  // Slot order is reversed for MSB-first streams.
  assign slot_idx = MSB_FIRST ? (3'd7 - count_reg) : count_reg;

  // Only the bit that completes a byte can stall; it waits until the
  // output buffer is free or being drained in the same cycle.
  assign bit_ready = !((count_reg == 3'd7) && valid_reg && !out_ready);
  assign accept    = bit_valid && bit_ready;
  // A flush discards whatever bit is accepted alongside it.
  assign take      = accept && !flush;
  assign complete  = take && (count_reg == 3'd7);

  // 1:8 demux: decode the slot and merge the incoming bit into that slot only.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign slot_onehot[gi] = (slot_idx == 3'(gi));
      assign asm_next[gi]    = (take && slot_onehot[gi]) ? bit_in : asm_reg[gi];
    end
  endgenerate

  // Partial-byte state: slot counter and assembly register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 3'd0;
      asm_reg   <= 8'd0;
    end else if (flush) begin
      count_reg <= 3'd0;
      asm_reg   <= 8'd0;
    end else if (take) begin
      count_reg <= count_reg + 3'd1;
      asm_reg   <= complete ? 8'd0 : asm_next;
    end
  end

  // Output buffer: load on completion, otherwise clear valid when consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg  <= 8'd0;
      valid_reg <= 1'b0;
    end else if (complete) begin
      word_reg  <= asm_next;
      valid_reg <= 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_word  = word_reg;
  assign out_valid = valid_reg;
  assign bit_count = count_reg;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Directed testbench for demux1_8_deser: one LSB-first and one MSB-first
// instance share the same stimulus; expected values are hand-computed.
module tb_demux1_8_deser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       bit_ready0, bit_ready1;
  logic [7:0] out_word0, out_word1;
  logic       out_valid0, out_valid1;
  logic [7:0] slot0, slot1;
  logic [2:0] count0, count1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux1_8_deser #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready0), .flush(flush), .out_word(out_word0),
    .out_valid(out_valid0), .out_ready(out_ready), .slot_onehot(slot0),
    .bit_count(count0)
  );

  demux1_8_deser #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready1), .flush(flush), .out_word(out_word1),
    .out_valid(out_valid1), .out_ready(out_ready), .slot_onehot(slot1),
    .bit_count(count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Send a byte in LSB-first order (matches the MSB_FIRST=0 instance).
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send(v[i]);
  endtask

  logic [7:0] stream;
  logic [7:0] byte2;

  initial begin
    // Reset state
    #3;
    chk("rst_word", out_word0, 8'h00);
    chk("rst_valid", out_valid0, 1'b0);
    chk("rst_count", count0, 3'd0);
    chk("rst_slot0", slot0, 8'h01);
    chk("rst_slot1", slot1, 8'h80);
    tick();
    reset = 1'b1;
    tick();

    // Stream 1,0,1,1,0,0,1,0 with the consumer always ready
    out_ready = 1'b1;
    stream = 8'b0100_1101;  // stream[i] is the i-th bit sent
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("slot_lsb_%0d", i), slot0, 8'h01 << i);
      chk($sformatf("slot_msb_%0d", i), slot1, 8'h80 >> i);
      send(stream[i]);
    end
    chk("lsb_word", out_word0, 8'h4D);
    chk("lsb_valid", out_valid0, 1'b1);
    chk("msb_word", out_word1, 8'hB2);
    chk("msb_valid", out_valid1, 1'b1);
    chk("slot_wrap0", slot0, 8'h01);
    chk("slot_wrap1", slot1, 8'h80);
    tick();
    chk("one_cycle_valid", out_valid0, 1'b0);

    // Backpressure: A5 held, 3C assembles behind it, completing bit stalls
    out_ready = 1'b0;
    send_byte(8'hA5);
    chk("bp_word_a5", out_word0, 8'hA5);
    chk("bp_valid_a5", out_valid0, 1'b1);
    byte2 = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_ready_%0d", i), bit_ready0, 1'b1);
      send(byte2[i]);
    end
    bit_valid = 1'b1;
    bit_in    = byte2[7];
    #1;
    chk("bp_stall_ready", bit_ready0, 1'b0);
    tick();
    tick();
    chk("bp_hold_word", out_word0, 8'hA5);
    chk("bp_hold_count", count0, 3'd7);
    chk("bp_hold_valid", out_valid0, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bit_ready0, 1'b1);
    tick();
    bit_valid = 1'b0;
    chk("bp_word_3c", out_word0, 8'h3C);
    chk("bp_valid_3c", out_valid0, 1'b1);
    tick();
    chk("bp_drained", out_valid0, 1'b0);

    // Simultaneous consume and complete: no bubble
    out_ready = 1'b0;
    send_byte(8'h5A);
    byte2 = 8'hC3;
    for (int i = 0; i < 7; i++) send(byte2[i]);
    chk("sim_pre_word", out_word0, 8'h5A);
    chk("sim_pre_valid", out_valid0, 1'b1);
    out_ready = 1'b1;
    send(byte2[7]);
    chk("sim_valid_kept", out_valid0, 1'b1);
    chk("sim_word_new", out_word0, 8'hC3);
    tick();
    chk("sim_drained", out_valid0, 1'b0);

    // Flush after 5 bits, with a bit offered in the flush cycle
    for (int i = 0; i < 5; i++) send(1'b1);
    chk("fl_pre_count", count0, 3'd5);
    flush = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    #1;
    chk("fl_ready", bit_ready0, 1'b1);
    tick();
    flush = 1'b0;
    bit_valid = 1'b0;
    chk("fl_count", count0, 3'd0);
    chk("fl_slot", slot0, 8'h01);
    chk("fl_valid", out_valid0, 1'b0);
    // Three zeros after the flush expose any residue of flushed ones
    send_byte(8'hF8);
    chk("fl_residue_word", out_word0, 8'hF8);
    tick();
    send_byte(8'hFF);
    chk("fl_ff_word", out_word0, 8'hFF);
    chk("fl_ff_valid", out_valid0, 1'b1);

    // Flush leaves a held output byte alone
    out_ready = 1'b0;
    tick();
    send(1'b0);
    send(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_held_valid", out_valid0, 1'b1);
    chk("fl_held_word", out_word0, 8'hFF);
    chk("fl_held_count", count0, 3'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_held_drain", out_valid0, 1'b0);

    // Asynchronous reset mid-byte with a byte held
    out_ready = 1'b0;
    send_byte(8'h81);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("ar_pre_count", count0, 3'd3);
    chk("ar_pre_valid", out_valid0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_word", out_word0, 8'h00);
    chk("ar_valid", out_valid0, 1'b0);
    chk("ar_count", count0, 3'd0);
    chk("ar_slot0", slot0, 8'h01);
    chk("ar_slot1", slot1, 8'h80);
    #2;
    reset = 1'b1;
    tick();
    tick();
    chk("ar_no_pulse", out_valid0, 1'b0);
    chk("ar_post_count", count0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
